// File: rtl/por_seq_pkg.sv
// Shared types and helpers for the power-on-reset sequencer.
// Holds the FSM state encoding and the short-mode counter step function.
package por_seq_pkg;

    typedef enum logic [2:0] {
        SYNC    = 3'd0,
        STARTUP = 3'd1,
        POR     = 3'd2,
        RELEASE = 3'd3,
        DONE    = 3'd4
    } state_t;

    localparam int SHORT_STEPS_LOG2 = 4;

    // Short mode fills the low (w-4) bits and then carries into the top nibble,
    // so a counter of width w (< 32) reaches all-ones in 16 steps from zero.
    function automatic logic [31:0] short_next(input logic [31:0] cnt, input int w);
        logic [31:0] lowmask;
        logic [31:0] allones;
        logic [31:0] ored;
        lowmask = (32'd1 << (w - SHORT_STEPS_LOG2)) - 32'd1;
        allones = (32'd1 << w) - 32'd1;
        ored    = cnt | lowmask;
        short_next = (ored == allones) ? allones : ored + 32'd1;
    endfunction

endpackage

// File: rtl/por_seq_cnt.sv
// Saturating one-shot counter with synchronous clear and a short (16-step) test mode.
// Latency: o_term is registered state (all-ones); no backpressure.
module por_seq_cnt
    import por_seq_pkg::*;
#(
    parameter int W = 9
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_en,
    input  logic i_short,
    output logic o_term
);

    logic [W-1:0] r_cnt;
    logic [W-1:0] w_nxt;

    assign o_term = &r_cnt;

    always_comb begin
        w_nxt = r_cnt;
        if (i_clr) begin
            w_nxt = '0;
        end else if (i_en) begin
            if (i_short) begin
                w_nxt = W'(short_next(32'(r_cnt), W));
            end else if (!o_term) begin
                w_nxt = r_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_nxt;
        end
    end

endmodule

// File: rtl/por_seq.sv
// Power-on-reset sequencer: startup and POR one-shots, then ordered release of N_CH resets.
// Optional debug ports under POR_SEQ_DEBUG_EN; rst_n/por_unbuf/seq_done are flop outputs.
module por_seq
    import por_seq_pkg::*;
#(
    parameter int N_CH   = 4,
    parameter int ST_W   = 9,
    parameter int POR_W  = 15,
    parameter int GAP_W  = 6,
    parameter int TRIP_W = 3
) (
    input  logic                     osc_ck,
    input  logic                     pwup_filt,
    input  logic [TRIP_W-1:0]        otrip,
    input  logic                     force_pdn,
    input  logic                     force_rc_osc,
    input  logic                     force_short_oneshot,
    input  logic                     bod_trip,
    output logic                     osc_ena,
    output logic [(1<<TRIP_W)-1:0]   otrip_decoded,
    output logic                     force_pdnb,
    output logic                     por_unbuf,
    output logic [N_CH-1:0]          rst_n,
    output logic                     seq_done
`ifdef POR_SEQ_DEBUG_EN
    ,
    output logic                     osc_ck_256,
    output logic [2:0]               seq_state,
    output logic                     startup_timed_out,
    output logic                     por_timed_out
`endif
);

    localparam int              DEC_W  = 1 << TRIP_W;
    localparam logic [DEC_W-1:0] DEC_ONE = DEC_W'(1);
    localparam logic [N_CH-1:0]  CH_ONE  = N_CH'(1);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [2:0]      r_sync;
    logic [1:0]      r_bod;
    logic            w_bod;
    logic            w_st_term;
    logic            w_por_term;
    logic            w_gap_term;
    logic [N_CH-1:0] r_rst_n;
    logic [N_CH-1:0] w_rst_nxt;
    logic            r_por;
    logic            r_done;

    always_ff @(posedge osc_ck or negedge pwup_filt) begin
        if (!pwup_filt) begin
            r_sync <= '0;
            r_bod  <= '0;
        end else begin
            r_sync <= {r_sync[1:0], 1'b1};
            r_bod  <= {r_bod[0], bod_trip};
        end
    end

    assign w_bod = r_bod[1];

    por_seq_cnt #(.W(ST_W)) u_st_cnt (
        .i_clk   (osc_ck),
        .i_rst_n (pwup_filt),
        .i_clr   (r_state != STARTUP),
        .i_en    (1'b1),
        .i_short (force_short_oneshot),
        .o_term  (w_st_term)
    );

    // A held brownout pins the POR count at zero so the full POR time restarts on release.
    por_seq_cnt #(.W(POR_W)) u_por_cnt (
        .i_clk   (osc_ck),
        .i_rst_n (pwup_filt),
        .i_clr   ((r_state != POR) || w_bod),
        .i_en    (1'b1),
        .i_short (force_short_oneshot),
        .o_term  (w_por_term)
    );

    por_seq_cnt #(.W(GAP_W)) u_gap_cnt (
        .i_clk   (osc_ck),
        .i_rst_n (pwup_filt),
        .i_clr   ((r_state != RELEASE) || w_gap_term),
        .i_en    (1'b1),
        .i_short (force_short_oneshot),
        .o_term  (w_gap_term)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            SYNC:    if (r_sync[2]) w_state_nxt = STARTUP;
            STARTUP: if (w_st_term) w_state_nxt = POR;
            POR: begin
                if (w_bod)           w_state_nxt = POR;
                else if (w_por_term) w_state_nxt = RELEASE;
            end
            RELEASE: begin
                if (w_bod)                  w_state_nxt = POR;
                else if (r_rst_n[N_CH-1])   w_state_nxt = DONE;
            end
            DONE:    if (w_bod) w_state_nxt = POR;
            default: w_state_nxt = SYNC;
        endcase
    end

    // Channels release as a thermometer: bit 0 on entry, one more per gap expiry.
    always_comb begin
        w_rst_nxt = '0;
        case (w_state_nxt)
            RELEASE: begin
                if (r_state != RELEASE) w_rst_nxt = CH_ONE;
                else if (w_gap_term)    w_rst_nxt = (r_rst_n << 1) | CH_ONE;
                else                    w_rst_nxt = r_rst_n;
            end
            DONE:    w_rst_nxt = '1;
            default: w_rst_nxt = '0;
        endcase
    end

    always_ff @(posedge osc_ck or negedge pwup_filt) begin
        if (!pwup_filt) begin
            r_state <= SYNC;
            r_rst_n <= '0;
            r_por   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_rst_n <= w_rst_nxt;
            r_por   <= (w_state_nxt == POR);
            r_done  <= (w_state_nxt == DONE);
        end
    end

    assign rst_n         = r_rst_n;
    assign por_unbuf     = r_por;
    assign seq_done      = r_done;
    assign force_pdnb    = ~force_pdn;
    assign otrip_decoded = DEC_ONE << otrip;
    assign osc_ena       = force_rc_osc | (pwup_filt & ~r_done);

`ifdef POR_SEQ_DEBUG_EN
    logic [6:0] r_div;
    logic       r_ck256;
    logic       r_st_to;
    logic       r_por_to;

    always_ff @(posedge osc_ck or negedge pwup_filt) begin
        if (!pwup_filt) begin
            r_div    <= '0;
            r_ck256  <= 1'b0;
            r_st_to  <= 1'b0;
            r_por_to <= 1'b0;
        end else begin
            if (!r_sync[2]) begin
                r_div   <= '0;
                r_ck256 <= 1'b0;
            end else begin
                r_div <= r_div + 7'd1;
                if (r_div == 7'd127) r_ck256 <= ~r_ck256;
            end
            if (w_st_term)  r_st_to  <= 1'b1;
            if (w_por_term) r_por_to <= 1'b1;
        end
    end

    assign osc_ck_256        = r_ck256;
    assign seq_state         = r_state;
    assign startup_timed_out = r_st_to;
    assign por_timed_out     = r_por_to;
`endif

endmodule
